// File: rtl/map_rom_arbiter_pkg.sv
// map_pkg: shared map dimensions, sequencer state encoding and owner tags for the map ROM arbiter
package map_pkg;
    localparam int MAP_W_DEF = 30;
    localparam int MAP_H_DEF = 21;
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        ADDR = 3'b010,
        DATA = 3'b100
    } state_t;
    localparam logic OWN_RENDER = 1'b0;
    localparam logic OWN_COLL   = 1'b1;
endpackage

// File: rtl/map_rom_arbiter_priority.sv
// map_arb_priority: fixed render-first winner select with a collision starvation guard
module map_arb_priority
    import map_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
)(
    input  logic clk,
    input  logic reset,
    input  logic idle,
    input  logic render_req,
    input  logic coll_req,
    output logic winner
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
    logic [CW-1:0] cnt;
    logic coll_wins;
    // Collision wins when render is absent or when it has lost too often in a row.
    always_comb begin
        coll_wins = coll_req && (!render_req || cnt == LIMIT);
        winner = coll_wins ? OWN_COLL : OWN_RENDER;
    end
    // Count idle-edge losses of a pending collision request; clear when it is granted.
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (idle && coll_req)
            cnt <= coll_wins ? '0 : (cnt == LIMIT ? cnt : cnt + 1'b1);
    end
endmodule

// File: rtl/map_rom_arbiter.sv
// map_rom_arbiter: shares the map ROM between renderer row fetches and collision tile lookups (optional MAP_ARB_STATS_EN adds counters)
module map_rom_arbiter
    import map_pkg::*;
#(
    parameter int MAP_W        = MAP_W_DEF,
    parameter int MAP_H        = MAP_H_DEF,
    parameter int ADDRW        = 5,
    parameter int COLW         = 5,
    parameter int STARVE_LIMIT = 8
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             render_req,
    input  logic [ADDRW-1:0] render_row,
    output logic             render_gnt,
    output logic             render_valid,
    output logic [MAP_W-1:0] render_data,
    input  logic             coll_req,
    input  logic [ADDRW-1:0] coll_row,
    input  logic [COLW-1:0]  coll_col,
    output logic             coll_gnt,
    output logic             coll_valid,
    output logic             coll_hit,
    output logic [ADDRW-1:0] rom_addr,
    input  logic [MAP_W-1:0] rom_data
`ifdef MAP_ARB_STATS_EN
    ,
    output logic [15:0]      stat_render_cnt,
    output logic [15:0]      stat_coll_cnt,
    output logic [15:0]      stat_starve_cnt
`endif
);
    state_t state, state_n;
    logic owner, oob, winner, any_req, start;
    logic row_oob_r, row_oob_c, col_oob_c;
    logic [COLW-1:0] col;

    map_arb_priority #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
        .clk        (clk),
        .reset      (reset),
        .idle       (state == IDLE),
        .render_req (render_req),
        .coll_req   (coll_req),
        .winner     (winner)
    );

    // Request detection, bounds flags and the three-step sequence IDLE -> ADDR -> DATA.
    always_comb begin
        any_req = render_req || coll_req;
        start = state == IDLE && any_req;
        row_oob_r = {1'b0, render_row} >= (ADDRW + 1)'(MAP_H);
        row_oob_c = {1'b0, coll_row} >= (ADDRW + 1)'(MAP_H);
        col_oob_c = {1'b0, coll_col} >= (COLW + 1)'(MAP_W);
        state_n = state == IDLE ? (any_req ? ADDR : IDLE) : state == ADDR ? DATA : IDLE;
    end

    // Latch the winner's operands at grant, pulse gnt/valid, capture results at the DATA edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= OWN_RENDER;
            oob <= 1'b0;
            col <= '0;
            rom_addr <= '0;
            render_gnt <= 1'b0;
            coll_gnt <= 1'b0;
            render_valid <= 1'b0;
            coll_valid <= 1'b0;
            render_data <= '0;
            coll_hit <= 1'b0;
        end else begin
            state <= state_n;
            render_gnt <= start && winner == OWN_RENDER;
            coll_gnt <= start && winner == OWN_COLL;
            render_valid <= state == DATA && owner == OWN_RENDER;
            coll_valid <= state == DATA && owner == OWN_COLL;
            if (start) begin
                owner <= winner;
                col <= coll_col;
                oob <= winner == OWN_COLL ? row_oob_c || col_oob_c : row_oob_r;
                rom_addr <= winner == OWN_COLL ? (row_oob_c || col_oob_c ? '0 : coll_row)
                                               : (row_oob_r ? '0 : render_row);
            end
            if (state == DATA && owner == OWN_RENDER)
                render_data <= oob ? '0 : rom_data;
            if (state == DATA && owner == OWN_COLL)
                coll_hit <= oob || rom_data[col];
        end
    end

`ifdef MAP_ARB_STATS_EN
    // Saturating counts of completed transactions and starvation-forced collision grants.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_render_cnt <= '0;
            stat_coll_cnt <= '0;
            stat_starve_cnt <= '0;
        end else begin
            if (state == DATA && owner == OWN_RENDER && stat_render_cnt != 16'hffff)
                stat_render_cnt <= stat_render_cnt + 16'd1;
            if (state == DATA && owner == OWN_COLL && stat_coll_cnt != 16'hffff)
                stat_coll_cnt <= stat_coll_cnt + 16'd1;
            if (start && render_req && winner == OWN_COLL && stat_starve_cnt != 16'hffff)
                stat_starve_cnt <= stat_starve_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_map_rom_arbiter.sv
// tb_map_rom_arbiter: directed scoreboard bench for the map ROM arbiter
module tb_map_rom_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic render_req = 1'b0;
    logic coll_req = 1'b0;
    logic [4:0] render_row = '0;
    logic [4:0] coll_row = '0;
    logic [4:0] coll_col = '0;
    logic render_gnt, render_valid, coll_gnt, coll_valid, coll_hit;
    logic [29:0] render_data, rom_data;
    logic [4:0] rom_addr;
    logic [29:0] rom [0:20];

    typedef struct {
        logic [29:0] d;
        int gnt_at;
        int addr;
    } ent_t;
    ent_t rq[$];
    ent_t cq[$];
    int checks = 0;
    int failures = 0;
    int ncyc = 0;
    bit hold_render = 0;
    logic [29:0] prev_rd;
    logic prev_hit;

    map_rom_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .render_req   (render_req),
        .render_row   (render_row),
        .render_gnt   (render_gnt),
        .render_valid (render_valid),
        .render_data  (render_data),
        .coll_req     (coll_req),
        .coll_row     (coll_row),
        .coll_col     (coll_col),
        .coll_gnt     (coll_gnt),
        .coll_valid   (coll_valid),
        .coll_hit     (coll_hit),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data)
    );

    always #5 clk = ~clk;

    // Synchronous-read ROM model
    always @(posedge clk) rom_data <= rom_addr < 5'd21 ? rom[rom_addr] : '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void exp_render(input logic [4:0] row, input int at);
        ent_t e;
        e.d = row < 5'd21 ? rom[row] : '0;
        e.gnt_at = at;
        e.addr = row < 5'd21 ? int'(row) : -1;
        rq.push_back(e);
    endfunction

    function automatic void exp_coll(input logic [4:0] row, input logic [4:0] col, input int at);
        ent_t e;
        logic [29:0] w;
        bit oob;
        oob = row >= 5'd21 || col >= 5'd30;
        w = oob ? '0 : rom[row];
        e.d = oob ? 30'd1 : {29'd0, w[col]};
        e.gnt_at = at;
        e.addr = oob ? 0 : int'(row);
        cq.push_back(e);
    endfunction

    task automatic step();
        ent_t e;
        @(negedge clk);
        ncyc++;
        if (render_gnt) begin
            chk("render_gnt_pending", 32'(rq.size() != 0), 1);
            if (rq.size() != 0) begin
                chk("render_gnt_cycle", ncyc, rq[0].gnt_at);
                if (rq[0].addr >= 0) chk("render_rom_addr", rom_addr, rq[0].addr);
            end
            if (!hold_render) begin
                render_req = 1'b0;
                render_row = ~render_row;
            end
        end
        if (coll_gnt) begin
            chk("coll_gnt_pending", 32'(cq.size() != 0), 1);
            if (cq.size() != 0) begin
                chk("coll_gnt_cycle", ncyc, cq[0].gnt_at);
                chk("coll_rom_addr", rom_addr, cq[0].addr);
            end
            coll_req = 1'b0;
            coll_row = ~coll_row;
            coll_col = ~coll_col;
            if (hold_render) begin
                hold_render = 0;
                render_req = 1'b0;
            end
        end
        if (render_valid) begin
            chk("render_valid_pending", 32'(rq.size() != 0), 1);
            if (rq.size() != 0) begin
                e = rq.pop_front();
                chk("render_valid_cycle", ncyc, e.gnt_at + 2);
                chk("render_data", render_data, e.d);
            end
        end else if (!reset) chk("render_data_held", render_data, prev_rd);
        if (coll_valid) begin
            chk("coll_valid_pending", 32'(cq.size() != 0), 1);
            if (cq.size() != 0) begin
                e = cq.pop_front();
                chk("coll_valid_cycle", ncyc, e.gnt_at + 2);
                chk("coll_hit", coll_hit, e.d[0]);
            end
        end else if (!reset) chk("coll_hit_held", coll_hit, prev_hit);
        prev_rd = render_data;
        prev_hit = coll_hit;
    endtask

    task automatic drain(input int budget);
        int i = 0;
        while ((rq.size() != 0 || cq.size() != 0) && i < budget) begin
            step();
            i++;
        end
        chk("drain_outstanding", rq.size() + cq.size(), 0);
        rq.delete();
        cq.delete();
        repeat (3) step();
    endtask

    initial begin
        for (int i = 0; i < 21; i++) rom[i] = 30'(i * 32'h0135_79BD);
        rom[3] = 30'h2AAA_AAAA;
        rom[5] = 30'h2000_0001;
        step();
        step();
        chk("reset_render_gnt", render_gnt, 0);
        chk("reset_render_valid", render_valid, 0);
        chk("reset_render_data", render_data, 0);
        chk("reset_coll_gnt", coll_gnt, 0);
        chk("reset_coll_valid", coll_valid, 0);
        chk("reset_coll_hit", coll_hit, 0);
        chk("reset_rom_addr", rom_addr, 0);
        reset = 1'b0;
        render_row = 5'd5; render_req = 1'b1; exp_render(5'd5, ncyc + 1);
        drain(10);
        coll_row = 5'd3; coll_col = 5'd29; coll_req = 1'b1; exp_coll(5'd3, 5'd29, ncyc + 1);
        drain(10);
        coll_row = 5'd3; coll_col = 5'd0; coll_req = 1'b1; exp_coll(5'd3, 5'd0, ncyc + 1);
        drain(10);
        render_row = 5'd5; render_req = 1'b1;
        coll_row = 5'd3; coll_col = 5'd29; coll_req = 1'b1;
        exp_render(5'd5, ncyc + 1);
        exp_coll(5'd3, 5'd29, ncyc + 4);
        drain(15);
        for (int r = 0; r < 2; r++) begin
            hold_render = 1; render_row = 5'd7; render_req = 1'b1;
            coll_row = 5'd3; coll_col = 5'd29; coll_req = 1'b1;
            for (int i = 0; i < 8; i++) exp_render(5'd7, ncyc + 1 + 3 * i);
            exp_coll(5'd3, 5'd29, ncyc + 25);
            drain(40);
        end
        render_row = 5'd2; render_req = 1'b1; exp_render(5'd2, ncyc + 1);
        step();
        coll_row = 5'd3; coll_col = 5'd29; coll_req = 1'b1;
        step();
        coll_req = 1'b0;
        drain(10);
        render_row = 5'd25; render_req = 1'b1; exp_render(5'd25, ncyc + 1);
        drain(10);
        coll_row = 5'd21; coll_col = 5'd4; coll_req = 1'b1; exp_coll(5'd21, 5'd4, ncyc + 1);
        drain(10);
        render_row = 5'd5; render_req = 1'b1; exp_render(5'd5, ncyc + 1);
        drain(10);
        render_row = 5'd5; render_req = 1'b1; exp_render(5'd5, ncyc + 1);
        step();
        reset = 1'b1;
        rq.delete();
        step();
        reset = 1'b0;
        chk("midreset_render_data", render_data, 0);
        chk("midreset_coll_hit", coll_hit, 0);
        chk("midreset_render_valid", render_valid, 0);
        chk("midreset_rom_addr", rom_addr, 0);
        repeat (4) step();
        render_row = 5'd5; render_req = 1'b1; exp_render(5'd5, ncyc + 1);
        drain(10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/map_rom_arbiter.md
Name: map_rom_arbiter

Overview:
- Shares the single-port, synchronous-read map ROM (30 bits wide, 21 rows) between two requesters.
  - Renderer: fetches one full map row per scanline during horizontal blanking.
  - Collision checker: fetches one tile bit at the player's (x, y) after every move.
- Sits between the map ROM instance and the game logic / VGA pixel path.
- Contains a 3-state access sequencer, a fixed-priority arbiter with a starvation guard, and output capture registers.

Parameters:
- MAP_W, 30, map width in tiles (ROM word width).
- MAP_H, 21, map height in rows (ROM depth).
- ADDRW, 5, row address width (≥ clog2(MAP_H)).
- COLW, 5, column index width (≥ clog2(MAP_W)).
- STARVE_LIMIT, 8, consecutive cycles a pending collision request may lose before it is forced to win.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- render_req  in  1  renderer requests a row; held until render_gnt
- render_row  in  ADDRW  row to fetch
- render_gnt  out  1  one-cycle grant pulse
- render_valid  out  1  one-cycle pulse: render_data updated
- render_data  out  MAP_W  last fetched row, held until the next render completion
- coll_req  in  1  collision checker request; held until coll_gnt
- coll_row  in  ADDRW  player y
- coll_col  in  COLW  player x
- coll_gnt  out  1  one-cycle grant pulse
- coll_valid  out  1  one-cycle pulse: coll_hit updated
- coll_hit  out  1  1 = wall (or out of bounds) at the requested tile; held
- rom_addr  out  ADDRW  address to the ROM (registered)
- rom_data  in  MAP_W  ROM data_out, valid one cycle after rom_addr changes

Behaviour:
- Reset values: all outputs 0; state IDLE; starvation counter 0.
- FSM states and transitions:
  - IDLE: at a clock edge with any request pending, pick a winner. Register rom_addr, the owner tag, and the column/out-of-range flag. Pulse that requester's gnt (high for the following cycle). Go to ADDR.
  - ADDR: ROM samples the address. Go to DATA unconditionally.
  - DATA: at this edge, capture rom_data for the owner and pulse its valid for the following cycle. Go to IDLE.
- Latency: request sampled at edge k → gnt during cycle k+1 → valid during cycle k+3.
- Throughput: one transaction per 3 cycles; only one transaction is ever outstanding.
- Arbitration:
  - Render wins when both requesters are pending, unless the starvation counter equals STARVE_LIMIT; then collision wins.
  - Counter increments each IDLE-edge where coll_req is pending but loses, clears on coll_gnt, and saturates at STARVE_LIMIT.
- Operand sampling: row/col are sampled only at the grant edge. Later changes do not affect the transaction in flight.
- Request withdrawal: deasserting a req before its grant is legal; no grant or valid is issued.
- Collision result: coll_hit = rom_data[coll_col] as sampled.
- Bounds handling:
  - coll_row ≥ MAP_H or coll_col ≥ MAP_W: still takes the full 3-cycle slot, rom_addr is driven to 0, and coll_hit = 1.
  - render_row ≥ MAP_H: still takes the full slot, render_data = 0.
- Idle ROM address: rom_addr holds its last value while IDLE.
- Mid-operation reset: the transaction is dropped, no valid is issued, and held data is cleared to 0.
- Output stability: render_data and coll_hit change only on their own valid edge.

Optional Feature:
- Macro: MAP_ARB_STATS_EN.
- When defined:
  - Adds outputs stat_render_cnt[15:0], stat_coll_cnt[15:0] and stat_starve_cnt[15:0].
  - They count completed render transactions, completed collision transactions, and forced (starvation) collision grants.
  - All three are saturating and cleared by reset.
- When undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package map_pkg holds:
  - MAP_W/MAP_H defaults.
  - FSM state encoding: one-hot IDLE=3'b001, ADDR=3'b010, DATA=3'b100.
  - Owner tag constants OWN_RENDER=1'b0, OWN_COLL=1'b1.
- One natural sub-module: map_arb_priority (combinational winner select plus the starvation counter register). The FSM and capture logic stay in the top module.

Test Plan:
- Single render request, row 5, ROM row 5 = 30'h2000_0001 → render_gnt in cycle k+1, render_valid in cycle k+3, render_data = 30'h2000_0001, rom_addr = 5.
- Single collision request, row 3, col 29, bit 29 set → coll_valid in cycle k+3 with coll_hit = 1; same request with col 0 and bit 0 clear → coll_hit = 0.
- Both requesting at the same edge → render granted first; collision granted 3 cycles later; the two valid pulses are 3 cycles apart.
- render_req held high continuously with coll_req pending → collision loses 8 times, then is granted, and the counter resets to 0.
- Bounds check with coll_row = 21, col = 4 → coll_hit = 1 and rom_addr = 0; render_row = 25 → render_data = 0, render_valid still pulses.
- Reset asserted in the ADDR state → no valid pulse; render_data = 0 and coll_hit = 0; the next request completes normally.
